pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-PC controller for the single-cycle CPU. Drives pc_result into the PC register every cycle
//  and reads the current PC back on pc_addr. Selects sequential/branch/jump/trap/return targets,
//  holds the PC on fetch stalls, traps on fetch timeout or a misaligned target, and supports halt.
//  Only sequential source of the PC value seen by instruction memory.
// PARAMETERS
//  WIDTH          32           PC / instruction address width
//  RESET_VECTOR   32'h0000_0000 PC driven while rst is high
//  TRAP_VECTOR    32'h0000_0100 PC of the trap handler
//  STALL_TIMEOUT  15           max consecutive cycles instr_ready may stay low (>=1)
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  pc_addr        in   WIDTH  current PC (PC register output)
//  instr_ready    in   1      imem has a valid instruction at pc_addr this cycle
//  branch_taken   in   1      conditional branch resolved taken
//  branch_target  in   WIDTH  branch destination
//  jump           in   1      unconditional jump
//  jump_target    in   WIDTH  jump destination
//  irq            in   1      level interrupt request
//  eret           in   1      return from trap
//  halt           in   1      halt instruction executing
//  pc_result      out  WIDTH  next PC, combinational; captured by PC register at next edge
//  fetch_valid    out  1      registered; current instruction is committed (RUN and instr_ready)
//  epc            out  WIDTH  registered exception PC
//  cause          out  2      registered: 0 none, 1 irq, 2 misaligned target, 3 fetch timeout
//  in_trap        out  1      registered; set on trap entry, cleared by eret
//  state          out  2      FSM state (debug)
// BEHAVIOUR
//  Reset (rst=1, any state): pc_result=RESET_VECTOR; state<=RUN; epc<=0; cause<=0; in_trap<=0;
//   fetch_valid<=0; stall_cnt<=0. Mid-operation reset aborts stall/trap without side effects.
//  States: RUN=0, STALL=1, TRAP=2, HALT=3. All redirects take effect at the next edge (latency 1).
//  seq = pc_addr + 4 (mod 2^WIDTH, wraps silently).
//  RUN, instr_ready=0: pc_result=pc_addr; ->STALL; stall_cnt<=1; all control inputs ignored.
//  RUN, instr_ready=1, priority high->low:
//   halt                      : pc_result=pc_addr; ->HALT.
//   irq & !in_trap            : tgt = the pc_result the lower rules would choose; epc<=tgt;
//                               cause<=1; ->TRAP (irq wins over a same-cycle branch/jump).
//   eret & in_trap            : pc_result=epc; in_trap<=0; cause<=0. eret with !in_trap = seq.
//   jump                      : pc_result=jump_target.
//   branch_taken              : pc_result=branch_target.
//   else                      : pc_result=seq.
//   A selected jump/branch target with [1:0]!=0: epc<=pc_addr; cause<=2; ->TRAP.
//  STALL: pc_result=pc_addr. instr_ready=1 -> RUN, stall_cnt<=0 (instruction evaluated next cycle).
//   instr_ready=0: stall_cnt++; when stall_cnt==STALL_TIMEOUT: epc<=pc_addr; cause<=3; ->TRAP.
//  TRAP (1 cycle): pc_result=TRAP_VECTOR; in_trap<=1; ->RUN. Nested trap while in_trap: irq masked;
//   misaligned/timeout still trap and overwrite epc/cause.
//  HALT: pc_result=pc_addr forever; all inputs ignored; exit only via rst.
//  fetch_valid<=(state==RUN && instr_ready && !rst).
// STRUCTURE
//  Shared package pc_seq_pkg: state encodings, cause codes, default vectors.
//  One sub-module: pc_stall_timer (counter + timeout compare). Next-PC mux and FSM inline.
// TESTING
//  1 Reset: rst=1 two cycles -> pc_result=0, state=RUN, in_trap=0; release -> PC steps 0,4,8.
//  2 Branch/jump: at PC=0x8 jump=1, jump_target=0x40 -> next PC 0x40; both jump and branch ->
//    jump_target wins.
//  3 Stall/timeout: instr_ready low 3 cycles at 0x10 -> PC held, then 0x14. Low 15 cycles ->
//    PC=0x100, epc=0x10, cause=3.
//  4 IRQ+branch: at 0x20 irq=1, branch_taken=1, target=0x80 -> PC=0x100, epc=0x80, cause=1, in_trap=1;
//    irq held -> ignored; eret -> PC=0x80.
//  5 Misaligned: jump_target=0x42 at 0x30 -> PC=0x100, epc=0x30, cause=2.
//  6 Halt+reset: halt at 0x50 -> PC stays 0x50 100 cycles despite irq; rst -> PC=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the next-PC sequencer: FSM states, trap causes, default vectors.
package pc_seq_pkg;

  localparam int unsigned DEF_WIDTH         = 32;
  localparam logic [31:0] DEF_RESET_VECTOR  = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR   = 32'h0000_0100;
  localparam int unsigned DEF_STALL_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_TRAP  = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_IRQ      = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } trap_cause_e;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the CPU datapath (master) and the next-PC sequencer (slave).
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] pc_addr;
  logic             instr_ready;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             irq;
  logic             eret;
  logic             halt;
  logic [WIDTH-1:0] pc_result;
  logic             fetch_valid;
  logic [WIDTH-1:0] epc;
  trap_cause_e      cause;
  logic             in_trap;
  pc_state_e        state;

  modport master (
    output pc_addr, instr_ready, branch_taken, branch_target, jump, jump_target,
           irq, eret, halt,
    input  pc_result, fetch_valid, epc, cause, in_trap, state
  );

  modport slave (
    input  pc_addr, instr_ready, branch_taken, branch_target, jump, jump_target,
           irq, eret, halt,
    output pc_result, fetch_valid, epc, cause, in_trap, state
  );
endinterface

// File: rtl/pc_stall_timer.sv
// Counts consecutive fetch-stall cycles and flags the cycle on which the stall limit is reached.
module pc_stall_timer
  import pc_seq_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = DEF_STALL_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic incr,
  input  logic clear,
  output logic timeout_c
);
  localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clear) begin
      stall_cnt_d = '0;
    end else if (load) begin
      stall_cnt_d = CNT_W'(1);
    end else if (incr) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // The current low cycle is the (count+1)-th in a row.
  assign timeout_c = (32'(stall_cnt_q) + 32'd1) >= STALL_TIMEOUT;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential/branch/jump/trap/return selection, fetch-stall hold and timeout,
// misaligned-target trap and halt.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH         = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR  = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] TRAP_VECTOR   = WIDTH'(DEF_TRAP_VECTOR),
  parameter int unsigned      STALL_TIMEOUT = DEF_STALL_TIMEOUT
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.slave  bus
);
  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  trap_cause_e      cause_q, cause_d;
  logic             in_trap_q, in_trap_d;
  logic             fetch_valid_q, fetch_valid_d;

  logic [WIDTH-1:0] next_pc_c;
  logic [WIDTH-1:0] seq_pc_c;
  logic [WIDTH-1:0] sel_tgt_c;
  logic             sel_ctl_c;
  logic             tmr_load, tmr_incr, tmr_clear, timeout_c;

  pc_stall_timer #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_stall_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .incr     (tmr_incr),
    .clear    (tmr_clear),
    .timeout_c(timeout_c)
  );

  // Target the non-trap rules would pick; sel_ctl_c marks a jump/branch that needs alignment.
  always_comb begin
    seq_pc_c  = bus.pc_addr + WIDTH'(4);
    sel_tgt_c = seq_pc_c;
    sel_ctl_c = 1'b0;
    if (bus.eret) begin
      sel_tgt_c = in_trap_q ? epc_q : seq_pc_c;
    end else if (bus.jump) begin
      sel_tgt_c = bus.jump_target;
      sel_ctl_c = 1'b1;
    end else if (bus.branch_taken) begin
      sel_tgt_c = bus.branch_target;
      sel_ctl_c = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    in_trap_d     = in_trap_q;
    fetch_valid_d = (state_q == ST_RUN) && bus.instr_ready;
    next_pc_c     = bus.pc_addr;
    tmr_load      = 1'b0;
    tmr_incr      = 1'b0;
    tmr_clear     = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (!bus.instr_ready) begin
          state_d  = ST_STALL;
          tmr_load = 1'b1;
        end else if (bus.halt) begin
          state_d = ST_HALT;
        end else if (bus.irq && !in_trap_q) begin
          epc_d   = sel_tgt_c;
          cause_d = CAUSE_IRQ;
          state_d = ST_TRAP;
        end else if (sel_ctl_c && is_misaligned(sel_tgt_c[1:0])) begin
          epc_d   = bus.pc_addr;
          cause_d = CAUSE_MISALIGN;
          state_d = ST_TRAP;
        end else begin
          next_pc_c = sel_tgt_c;
          if (bus.eret && in_trap_q) begin
            in_trap_d = 1'b0;
            cause_d   = CAUSE_NONE;
          end
        end
      end
      ST_STALL: begin
        if (bus.instr_ready) begin
          state_d   = ST_RUN;
          tmr_clear = 1'b1;
        end else if (timeout_c) begin
          epc_d     = bus.pc_addr;
          cause_d   = CAUSE_TIMEOUT;
          state_d   = ST_TRAP;
          tmr_clear = 1'b1;
        end else begin
          tmr_incr = 1'b1;
        end
      end
      ST_TRAP: begin
        next_pc_c = TRAP_VECTOR;
        in_trap_d = 1'b1;
        state_d   = ST_RUN;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (rst) begin
      next_pc_c = RESET_VECTOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      epc_q         <= '0;
      cause_q       <= CAUSE_NONE;
      in_trap_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
      in_trap_q     <= in_trap_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign bus.pc_result   = next_pc_c;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.epc         = epc_q;
  assign bus.cause       = cause_q;
  assign bus.in_trap     = in_trap_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: closes the PC register loop, checks every cycle against a behavioural
// model, and pins the model with directed literal expectations.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int unsigned W      = 32;
  localparam logic [31:0] RST_V  = 32'h0000_0000;
  localparam logic [31:0] TRAP_V = 32'h0000_0100;
  localparam int unsigned TMO    = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_reg = '0;

  pc_sequencer_if #(.WIDTH(W)) bus ();

  pc_sequencer #(
    .WIDTH        (W),
    .RESET_VECTOR (RST_V),
    .TRAP_VECTOR  (TRAP_V),
    .STALL_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // PC register owned by the CPU datapath.
  always @(posedge clk) pc_reg <= bus.pc_result;
  assign bus.pc_addr = pc_reg;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model state: what the sequencer is doing, in plain terms.
  logic [31:0] m_pc       = '0;
  bit          m_halted   = 1'b0;
  bit          m_trapping = 1'b0;
  int          m_low      = 0;
  logic [31:0] m_epc      = '0;
  int          m_cause    = 0;
  bit          m_in_trap  = 1'b0;
  bit          m_fv       = 1'b0;

  always @(negedge clk) begin : model_compare
    logic [31:0] exp_pc, seq, tgt, n_epc;
    int          exp_state, n_low, n_cause;
    bit          ctl, n_halted, n_trapping, n_in_trap, n_fv;

    exp_state  = m_halted ? 3 : m_trapping ? 2 : (m_low > 0) ? 1 : 0;
    exp_pc     = m_pc;
    n_halted   = m_halted;
    n_trapping = 1'b0;
    n_low      = m_low;
    n_epc      = m_epc;
    n_cause    = m_cause;
    n_in_trap  = m_in_trap;
    n_fv       = 1'b0;

    if (rst) begin
      exp_pc    = RST_V;
      n_halted  = 1'b0;
      n_low     = 0;
      n_epc     = '0;
      n_cause   = 0;
      n_in_trap = 1'b0;
    end else if (m_halted) begin
      exp_pc = m_pc;
    end else if (m_trapping) begin
      exp_pc    = TRAP_V;
      n_in_trap = 1'b1;
    end else if (m_low > 0) begin
      if (bus.instr_ready) n_low = 0;
      else if (m_low + 1 >= int'(TMO)) begin
        n_epc      = m_pc;
        n_cause    = 3;
        n_trapping = 1'b1;
        n_low      = 0;
      end else n_low = m_low + 1;
    end else if (!bus.instr_ready) begin
      n_low = 1;
    end else begin
      n_fv = 1'b1;
      seq  = m_pc + 32'd4;
      ctl  = 1'b0;
      if (bus.eret) tgt = m_in_trap ? m_epc : seq;
      else if (bus.jump) begin tgt = bus.jump_target; ctl = 1'b1; end
      else if (bus.branch_taken) begin tgt = bus.branch_target; ctl = 1'b1; end
      else tgt = seq;

      if (bus.halt) n_halted = 1'b1;
      else if (bus.irq && !m_in_trap) begin
        n_epc = tgt; n_cause = 1; n_trapping = 1'b1;
      end else if (ctl && (tgt % 4 != 0)) begin
        n_epc = m_pc; n_cause = 2; n_trapping = 1'b1;
      end else begin
        exp_pc = tgt;
        if (bus.eret && m_in_trap) begin n_in_trap = 1'b0; n_cause = 0; end
      end
    end

    if (check_en) begin
      check("pc_result",   bus.pc_result,             exp_pc);
      check("state",       32'(bus.state),            32'(exp_state));
      check("epc",         bus.epc,                   m_epc);
      check("cause",       32'(bus.cause),            32'(m_cause));
      check("in_trap",     32'(bus.in_trap),          32'(m_in_trap));
      check("fetch_valid", 32'(bus.fetch_valid),      32'(m_fv));
    end

    m_pc       = exp_pc;
    m_halted   = n_halted;
    m_trapping = n_trapping;
    m_low      = n_low;
    m_epc      = n_epc;
    m_cause    = n_cause;
    m_in_trap  = n_in_trap;
    m_fv       = n_fv;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_ctl();
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;
    bus.irq           = 1'b0;
    bus.eret          = 1'b0;
    bus.halt          = 1'b0;
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    bus.jump        = 1'b1;
    bus.jump_target = tgt;
    tick(1);
    clear_ctl();
  endtask

  initial begin
    clear_ctl();
    rst = 1'b1;

    // Reset and sequential stepping
    tick(1);
    check_en = 1'b1;
    tick(1);
    check("rst_pc", pc_reg, 32'h0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_in_trap", 32'(bus.in_trap), 32'd0);
    rst = 1'b0;
    tick(1);
    check("seq_pc4", pc_reg, 32'h4);
    check("seq_fv", 32'(bus.fetch_valid), 32'd1);
    tick(1);
    check("seq_pc8", pc_reg, 32'h8);

    // Jump, then jump beats branch
    jump_to(32'h40);
    check("jump_pc", pc_reg, 32'h40);
    bus.branch_taken = 1'b1; bus.branch_target = 32'h70;
    jump_to(32'h60);
    check("jump_over_branch", pc_reg, 32'h60);

    // Short stall, then timeout
    jump_to(32'h10);
    bus.instr_ready = 1'b0;
    tick(3);
    check("stall_hold_pc", pc_reg, 32'h10);
    check("stall_state", 32'(bus.state), 32'd1);
    bus.instr_ready = 1'b1;
    tick(1);
    check("stall_exit_pc", pc_reg, 32'h10);
    tick(1);
    check("stall_resume_pc", pc_reg, 32'h14);
    jump_to(32'h10);
    bus.instr_ready = 1'b0;
    tick(15);
    check("tmo_state", 32'(bus.state), 32'd2);
    check("tmo_epc", bus.epc, 32'h10);
    check("tmo_cause", 32'(bus.cause), 32'd3);
    bus.instr_ready = 1'b1;
    tick(1);
    check("tmo_pc", pc_reg, 32'h100);
    check("tmo_in_trap", 32'(bus.in_trap), 32'd1);
    bus.eret = 1'b1;
    tick(1);
    clear_ctl();
    check("eret_tmo_pc", pc_reg, 32'h10);

    // IRQ beats a same-cycle branch; masked while in trap
    jump_to(32'h20);
    bus.irq = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
    tick(1);
    check("irq_epc", bus.epc, 32'h80);
    check("irq_cause", 32'(bus.cause), 32'd1);
    bus.branch_taken = 1'b0;
    tick(1);
    check("irq_pc", pc_reg, 32'h100);
    check("irq_in_trap", 32'(bus.in_trap), 32'd1);
    tick(1);
    check("irq_masked_pc", pc_reg, 32'h104);
    bus.eret = 1'b1;
    tick(1);
    clear_ctl();
    check("irq_eret_pc", pc_reg, 32'h80);
    check("irq_eret_in_trap", 32'(bus.in_trap), 32'd0);

    // Misaligned jump, then nested misaligned branch inside the handler
    jump_to(32'h30);
    bus.jump = 1'b1; bus.jump_target = 32'h42;
    tick(1);
    clear_ctl();
    tick(1);
    check("mis_pc", pc_reg, 32'h100);
    check("mis_epc", bus.epc, 32'h30);
    check("mis_cause", 32'(bus.cause), 32'd2);
    bus.branch_taken = 1'b1; bus.branch_target = 32'h103;
    tick(1);
    clear_ctl();
    check("nested_epc", bus.epc, 32'h100);
    tick(1);
    check("nested_pc", pc_reg, 32'h100);
    bus.eret = 1'b1;
    tick(1);
    clear_ctl();

    // Address wrap and eret outside a trap
    jump_to(32'hFFFF_FFFC);
    check("wrap_hi", pc_reg, 32'hFFFF_FFFC);
    tick(1);
    check("wrap_zero", pc_reg, 32'h0);
    bus.eret = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h200;
    tick(1);
    clear_ctl();
    check("eret_no_trap", pc_reg, 32'h4);

    // Reset in the middle of a stall
    bus.instr_ready = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    check("midrst_pc", pc_reg, 32'h0);
    check("midrst_state", 32'(bus.state), 32'd0);
    rst = 1'b0;
    clear_ctl();

    // Halt ignores everything until reset
    jump_to(32'h50);
    bus.halt = 1'b1;
    tick(1);
    for (int i = 0; i < 100; i++) begin
      bus.halt = 1'b0; bus.irq = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h60;
      bus.instr_ready = i[0];
      tick(1);
    end
    check("halt_pc", pc_reg, 32'h50);
    check("halt_state", 32'(bus.state), 32'd3);
    rst = 1'b1;
    tick(1);
    check("halt_rst_pc", pc_reg, 32'h0);
    clear_ctl();
    rst = 1'b0;
    tick(1);
    check("post_halt_pc", pc_reg, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
